// File: rtl/tick_chain_pkg.sv
// Shared constants and helpers for the tick_chain cascaded timebase.
// Optional build macro used by the top: TICK_CHAIN_TOTAL_EN.
package tick_chain_pkg;

  localparam int MAX_STAGES    = 8;
  localparam int DEFAULT_WIDTH = 16;

  localparam logic [3*DEFAULT_WIDTH-1:0] DEFAULT_RELOADS = {16'd50, 16'd20, 16'd50};

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

  function automatic int minSelW(input int numStages);
    int w;
    w = 1;
    while ((1 << w) < numStages) w++;
    return w;
  endfunction

endpackage

// File: rtl/tick_chain_stage.sv
// One programmable down-count divider stage with its sticky pending/overrun flags.
module tick_stage #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_RELOAD = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ev_i,
  input  logic             wr_hit_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pending_clr_i,
  output logic             pulse_o,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] reload_o,
  output logic             pending_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             cntIsOne;

  assign cntIsOne = (cnt_q == WIDTH'(1));

  // A write to this stage restarts its phase, so it swallows any tick due the same cycle.
  assign pulse_o = rst_ni && ev_i && cntIsOne && (reload_q != '0) && !wr_hit_i;

  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (wr_hit_i) begin
      cnt_d    = wr_data_i;
      reload_d = wr_data_i;
    end else if (ev_i) begin
      if (cntIsOne) begin
        cnt_d = reload_q;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    pending_d = pulse_o | (pending_q & ~pending_clr_i);
    overrun_d = overrun_q;
    if (pulse_o && pending_q && !pending_clr_i) begin
      overrun_d = 1'b1;
    end else if (pending_clr_i && !pulse_o) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= RESET_RELOAD;
      reload_q  <= RESET_RELOAD;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign reload_o  = reload_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/tick_chain.sv
// Cascaded realtime timebase: NUM_STAGES programmable dividers with MCU-visible state.
// Define TICK_CHAIN_TOTAL_EN to build the free-running last-stage tick counter.
module tick_chain
  import tick_chain_pkg::*;
#(
  parameter int                          NUM_STAGES    = 3,
  parameter int                          WIDTH         = 16,
  parameter logic [NUM_STAGES*WIDTH-1:0] RESET_RELOADS = DEFAULT_RELOADS,
  parameter int                          SEL_W         = 2
) (
  input  logic                  sysclk,
  input  logic                  sysreset_n,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [WIDTH-1:0]      rd_count,
  output logic [WIDTH-1:0]      rd_reload,
  output logic [NUM_STAGES-1:0] pulse,
  output logic [NUM_STAGES-1:0] pending,
  input  logic [NUM_STAGES-1:0] pending_clr,
  output logic [NUM_STAGES-1:0] overrun,
  output logic [31:0]           tick_total
);

  if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES || SEL_W < minSelW(NUM_STAGES)) begin : gBadConfig
    $error("tick_chain: NUM_STAGES out of range or SEL_W too narrow");
  end

  logic [NUM_STAGES-1:0][WIDTH-1:0] cntArr;
  logic [NUM_STAGES-1:0][WIDTH-1:0] reloadArr;

  // Each stage keeps its own event/pulse nets so the carry ripple is a plain forward chain.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : gStage
    logic stageEv;
    logic stagePulse;
    logic wrHit;

    if (k == 0) begin : gFirst
      assign stageEv = enable;
    end else begin : gNext
      assign stageEv = gStage[k-1].stagePulse;
    end

    assign wrHit = wr_en && (wr_sel == SEL_W'(k));

    tick_stage #(
      .WIDTH        (WIDTH),
      .RESET_RELOAD (RESET_RELOADS[k*WIDTH +: WIDTH])
    ) uStage (
      .clk_i         (sysclk),
      .rst_ni        (sysreset_n),
      .ev_i          (stageEv),
      .wr_hit_i      (wrHit),
      .wr_data_i     (wr_data),
      .pending_clr_i (pending_clr[k]),
      .pulse_o       (stagePulse),
      .cnt_o         (cntArr[k]),
      .reload_o      (reloadArr[k]),
      .pending_o     (pending[k]),
      .overrun_o     (overrun[k])
    );

    assign pulse[k] = stagePulse;
  end

  always_comb begin
    rd_count  = '0;
    rd_reload = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (rd_sel == SEL_W'(k)) begin
        rd_count  = cntArr[k];
        rd_reload = reloadArr[k];
      end
    end
  end

`ifdef TICK_CHAIN_TOTAL_EN
  logic [31:0] total_q;

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      total_q <= '0;
    end else if (pulse[NUM_STAGES-1]) begin
      total_q <= total_q + 32'd1;
    end
  end

  assign tick_total = total_q;
`else
  assign tick_total = 32'h0;
`endif

endmodule

// File: tb/tb_tick_chain.sv
// Directed self-checking bench for tick_chain with default parameters.
// Expected tick_total depends on whether TICK_CHAIN_TOTAL_EN is defined.
module tb_tick_chain;
  import tick_chain_pkg::*;

  localparam int NS = 3;
  localparam int W  = 16;
  localparam int SW = 2;

`ifdef TICK_CHAIN_TOTAL_EN
  localparam logic [31:0] TOTAL_EXP = 32'd3;
`else
  localparam logic [31:0] TOTAL_EXP = 32'd0;
`endif

  logic          sysclk = 1'b0;
  logic          sysreset_n;
  logic          enable;
  logic          wr_en;
  logic [SW-1:0] wr_sel;
  logic [W-1:0]  wr_data;
  logic [SW-1:0] rd_sel;
  logic [W-1:0]  rd_count;
  logic [W-1:0]  rd_reload;
  logic [NS-1:0] pulse;
  logic [NS-1:0] pending;
  logic [NS-1:0] pending_clr;
  logic [NS-1:0] overrun;
  logic [31:0]   tick_total;

  int checks = 0;
  int errors = 0;

  always #10 sysclk = ~sysclk;

  tick_chain #(
    .NUM_STAGES    (NS),
    .WIDTH         (W),
    .RESET_RELOADS (DEFAULT_RELOADS),
    .SEL_W         (SW)
  ) dut (
    .sysclk      (sysclk),
    .sysreset_n  (sysreset_n),
    .enable      (enable),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .rd_sel      (rd_sel),
    .rd_count    (rd_count),
    .rd_reload   (rd_reload),
    .pulse       (pulse),
    .pending     (pending),
    .pending_clr (pending_clr),
    .overrun     (overrun),
    .tick_total  (tick_total)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic waitPulse(input int k, input int limit, output int n);
    n = 0;
    while (pulse[k] !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
  endtask

  task automatic applyStimulus(input logic [SW-1:0] sel, input logic [W-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = data;
    step(1);
    wr_en = 1'b0;
    #1;
  endtask

  task automatic readStage(input logic [SW-1:0] sel, output logic [W-1:0] c, output logic [W-1:0] r);
    rd_sel = sel;
    #1;
    c = rd_count;
    r = rd_reload;
  endtask

  initial begin
    int       n;
    logic     anyPulse;
    logic [W-1:0] c, r;
    logic [W-1:0] expReload [NS];
    expReload[0] = 16'd50;
    expReload[1] = 16'd20;
    expReload[2] = 16'd50;

    sysreset_n  = 1'b0;
    enable      = 1'b1;
    wr_en       = 1'b0;
    wr_sel      = '0;
    wr_data     = '0;
    rd_sel      = '0;
    pending_clr = '0;
    step(2);
    checkOutput("pulse_in_reset", 32'(pulse), 32'd0);
    sysreset_n = 1'b1;

    $display("[TB] reset values");
    readStage(2'd0, c, r);
    checkOutput("rst_cnt0", 32'(c), 32'd50);
    checkOutput("rst_reload0", 32'(r), 32'd50);
    readStage(2'd1, c, r);
    checkOutput("rst_reload1", 32'(r), 32'd20);
    readStage(2'd2, c, r);
    checkOutput("rst_cnt2", 32'(c), 32'd50);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_total", tick_total, 32'd0);

    $display("[TB] default periods");
    waitPulse(0, 100, n);
    checkOutput("first_pulse0_delay", n, 49);
    checkOutput("first_pulse0_upper", 32'(pulse[2:1]), 32'd0);
    step(1);
    checkOutput("pending0_set", 32'(pending[0]), 32'd1);
    waitPulse(0, 100, n);
    checkOutput("pulse0_period", n, 49);
    waitPulse(1, 2000, n);
    checkOutput("first_pulse1_delay", n, 900);
    checkOutput("pulse1_with_pulse0", 32'(pulse[0]), 32'd1);
    waitPulse(2, 60000, n);
    checkOutput("first_pulse2_delay", n, 49000);
    checkOutput("full_carry", 32'(pulse), 32'd7);
    readStage(2'd1, c, r);
    checkOutput("carry_cnt1", 32'(c), 32'd1);
    readStage(2'd2, c, r);
    checkOutput("carry_cnt2", 32'(c), 32'd1);

    $display("[TB] enable gap");
    step(11);
    enable = 1'b0;
    readStage(2'd0, c, r);
    checkOutput("gap_cnt_before", 32'(c), 32'd40);
    anyPulse = 1'b0;
    repeat (37) begin
      step(1);
      anyPulse = anyPulse | (|pulse);
    end
    checkOutput("gap_no_pulse", 32'(anyPulse), 32'd0);
    readStage(2'd0, c, r);
    checkOutput("gap_cnt_after", 32'(c), 32'd40);
    enable = 1'b1;
    waitPulse(0, 100, n);
    checkOutput("gap_resume_delay", n, 39);

    $display("[TB] write stage 0 = 1 on its tick");
    wr_en   = 1'b1;
    wr_sel  = 2'd0;
    wr_data = 16'd1;
    #1;
    checkOutput("write_beats_event", 32'(pulse[0]), 32'd0);
    step(1);
    wr_en = 1'b0;
    #1;
    checkOutput("passthrough_pulse0", 32'(pulse[0]), 32'd1);
    waitPulse(1, 100, n);
    checkOutput("pulse1_after_passthrough", n, 19);
    step(1);
    waitPulse(1, 100, n);
    checkOutput("pulse1_period20", n, 19);

    $display("[TB] disable stage 1");
    applyStimulus(2'd1, 16'd0);
    readStage(2'd1, c, r);
    checkOutput("disabled_reload1", 32'(r), 32'd0);
    checkOutput("disabled_cnt1", 32'(c), 32'd0);
    anyPulse = 1'b0;
    repeat (100) begin
      step(1);
      anyPulse = anyPulse | pulse[1] | pulse[2];
    end
    checkOutput("starved_no_pulse", 32'(anyPulse), 32'd0);
    checkOutput("stage0_still_running", 32'(pulse[0]), 32'd1);
    applyStimulus(2'd1, 16'd5);
    applyStimulus(2'd0, 16'd50);
    waitPulse(1, 400, n);
    checkOutput("pulse1_resume", n, 249);

    $display("[TB] pending/overrun flags");
    step(1);
    pending_clr = 3'b001;
    step(1);
    pending_clr = '0;
    checkOutput("quiet_clear_pending", 32'(pending[0]), 32'd0);
    checkOutput("quiet_clear_overrun", 32'(overrun[0]), 32'd0);
    waitPulse(0, 100, n);
    checkOutput("pulse0_after_clear", n, 48);
    pending_clr = 3'b001;
    step(1);
    pending_clr = '0;
    checkOutput("set_beats_clear", 32'(pending[0]), 32'd1);
    checkOutput("no_overrun_on_clear", 32'(overrun[0]), 32'd0);
    waitPulse(0, 100, n);
    step(1);
    checkOutput("overrun_set", 32'(overrun[0]), 32'd1);
    checkOutput("overrun_pending", 32'(pending[0]), 32'd1);
    pending_clr = 3'b001;
    step(1);
    pending_clr = '0;
    checkOutput("clear_both_flags", 32'({overrun[0], pending[0]}), 32'd0);

    $display("[TB] out-of-range select");
    applyStimulus(2'd3, 16'd7);
    readStage(2'd0, c, r);
    checkOutput("ignored_wr_reload0", 32'(r), 32'd50);
    readStage(2'd1, c, r);
    checkOutput("ignored_wr_reload1", 32'(r), 32'd5);
    readStage(2'd3, c, r);
    checkOutput("oor_rd_count", 32'(c), 32'd0);
    checkOutput("oor_rd_reload", 32'(r), 32'd0);

    $display("[TB] reset mid-count");
    applyStimulus(2'd0, 16'd7);
    applyStimulus(2'd1, 16'd9);
    applyStimulus(2'd2, 16'd11);
    step(5);
    sysreset_n = 1'b0;
    #3;
    checkOutput("midreset_pulse", 32'(pulse), 32'd0);
    step(2);
    sysreset_n = 1'b1;
    for (int k = 0; k < NS; k++) begin
      readStage(SW'(k), c, r);
      checkOutput($sformatf("rerst_cnt%0d", k), 32'(c), 32'(expReload[k]));
      checkOutput($sformatf("rerst_reload%0d", k), 32'(r), 32'(expReload[k]));
      step(1);
    end
    checkOutput("rerst_flags", 32'({overrun, pending}), 32'd0);
    checkOutput("rerst_total", tick_total, 32'd0);

    $display("[TB] tick_total with reloads 2/2/2");
    enable = 1'b0;
    sysreset_n = 1'b0;
    step(1);
    sysreset_n = 1'b1;
    applyStimulus(2'd0, 16'd2);
    applyStimulus(2'd1, 16'd2);
    applyStimulus(2'd2, 16'd2);
    enable = 1'b1;
    step(24);
    checkOutput("tick_total_24", tick_total, TOTAL_EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
